// File: rtl/div_if.sv
// Request/response bundle for the 32-bit divider.
// Handshake: a request is accepted on a rising edge with start=1 and a valid select while busy=0; done pulses for one cycle with result valid.
interface div_if;
  logic        start;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [4:0]  select;
  logic [31:0] result;
  logic        busy;
  logic        done;

  modport master (output start, data1, data2, select, input result, busy, done);
  modport slave  (input start, data1, data2, select, output result, busy, done);
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU (32-bit).
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow straight from IDLE.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    div_if.slave        bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, FIN = 2'd3} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvsr;
    logic [31:0] res_fix;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        sel_valid;
    logic        sel_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] trial;

    assign sel_valid  = (bus.select[4:2] == 3'b011);
    assign sel_signed = ~bus.select[0];
    assign a_neg      = sel_signed & bus.data1[31];
    assign b_neg      = sel_signed & bus.data2[31];
    assign mag_a      = a_neg ? (32'd0 - bus.data1) : bus.data1;
    assign mag_b      = b_neg ? (32'd0 - bus.data2) : bus.data2;
    // Shift in the next dividend bit and try to subtract; a set MSB means borrow.
    assign trial      = {rem, quo[31]} - {1'b0, dvsr};
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            dvsr       <= 32'd0;
            res_fix    <= 32'd0;
            is_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            bus.result <= 32'd0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && sel_valid) begin
                        quo      <= mag_a;
                        rem      <= 32'd0;
                        dvsr     <= mag_b;
                        is_rem   <= bus.select[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (bus.data2 == 32'd0);
                        cnt      <= 5'd0;
                        bus.busy <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (bus.data2 == 32'd0) begin
                            res_fix <= bus.select[1] ? bus.data1 : 32'hFFFF_FFFF;
                            state   <= FIN;
                        end else if (sel_signed && bus.data1 == 32'h8000_0000 &&
                                     bus.data2 == 32'hFFFF_FFFF) begin
                            res_fix <= bus.select[1] ? 32'd0 : 32'h8000_0000;
                            state   <= FIN;
                        end else begin
                            state   <= CALC;
                        end
`else
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= {rem[30:0], quo[31]};
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    // Divide by zero keeps the all-ones quotient regardless of dividend sign.
                    if (is_rem) res_fix <= neg_r ? (32'd0 - rem) : rem;
                    else        res_fix <= (neg_q && !div_zero) ? (32'd0 - quo) : quo;
                    state <= FIN;
                end
                FIN: begin
                    bus.result <= res_fix;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor checks each done pulse.
module tb_div_unit;

  localparam logic [4:0] OP_DIV = 5'b01100, OP_DIVU = 5'b01101,
                         OP_REM = 5'b01110, OP_REMU = 5'b01111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  div_if bus_if ();

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_div(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    sa = a;
    sb = b;
    case (sel)
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sb;
        return sr;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb;
        return sr;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0) return 1;
    if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 34;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus_if.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", bus_if.result, e);
        check("done_cycle", cyc, ec);
      end
    end
  end

  // ---------------- driver ----------------
  // inject_at: cycle after acceptance to fire a second START with new operands (0 = never).
  // abort_at: cycle after acceptance to pulse reset (0 = never).
  task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, input int abort_at);
    int n;
    int busy_low;
    bus_if.start  = 1'b1;
    bus_if.select = sel;
    bus_if.data1  = a;
    bus_if.data2  = b;
    exp_q.push_back(ref_div(sel, a, b));
    @(posedge clk);
    #1;
    exp_cyc_q.push_back(cyc + ref_lat(sel, a, b));
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.data1 = $urandom;
    bus_if.data2 = $urandom;
    n = 1;
    busy_low = 0;
    while (!bus_if.done && n < 100) begin
      if (!bus_if.busy) busy_low++;
      if (inject_at != 0 && n == inject_at) begin
        bus_if.start  = 1'b1;
        bus_if.select = OP_DIVU;
        bus_if.data1  = $urandom;
        bus_if.data2  = $urandom_range(1, 50);
      end else begin
        bus_if.start = 1'b0;
      end
      if (abort_at != 0 && n == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_result", bus_if.result, 32'd0);
        check("abort_done", {31'd0, bus_if.done}, 32'd0);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        return;
      end
      @(negedge clk);
      n++;
    end
    bus_if.start = 1'b0;
    check("done_seen", {31'd0, bus_if.done}, 32'd1);
    check("busy_during_op", busy_low, 0);
    check("busy_at_done", {31'd0, bus_if.busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] ops [4];
    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;
    bus_if.start  = 1'b0;
    bus_if.select = 5'd0;
    bus_if.data1  = 32'd0;
    bus_if.data2  = 32'd0;
    #1;
    check("reset_result", bus_if.result, 32'd0);
    check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    check("reset_done", {31'd0, bus_if.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_DIV,  32'd100,        32'd7, 0, 0);
    run_op(OP_REM,  32'hFFFF_FFF9,  32'd2, 0, 0);
    run_op(OP_REMU, 32'hFFFF_FFF9,  32'd2, 0, 0);
    run_op(OP_DIVU, 32'h1234_5678,  32'd0, 0, 0);
    run_op(OP_REM,  32'h1234_5678,  32'd0, 0, 0);
    run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
    run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
    run_op(OP_DIV,  32'hFFFF_FF9C,  32'd0, 0, 0);

    // Second START and new operands mid-operation must not disturb the first.
    run_op(OP_DIV,  32'd1000,       32'd7, 10, 0);
    repeat (40) @(negedge clk);

    // Unsupported select is ignored.
    bus_if.start  = 1'b1;
    bus_if.select = 5'b00000;
    bus_if.data1  = 32'd50;
    bus_if.data2  = 32'd5;
    @(negedge clk);
    bus_if.start = 1'b0;
    check("bad_select_busy", {31'd0, bus_if.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("bad_select_busy_late", {31'd0, bus_if.busy}, 32'd0);

    // Reset mid-operation aborts; next op runs normally.
    run_op(OP_DIV, 32'd123456, 32'd11, 0, 20);
    run_op(OP_DIV, 32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(ops[$urandom_range(0, 3)], pick_operand(), pick_operand(), 0, 0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 START  input  1  request strobe from the EX stage, sampled on the CLK rising edge.
REQ-005 DATA1  input  32  dividend (rs1 value).
REQ-006 DATA2  input  32  divisor (rs2 value).
REQ-007 SELECT  input  5  operation: 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
REQ-008 RESULT  output  32  quotient or remainder; held until the next completion.
REQ-009 BUSY  output  1  high from the cycle after an accepted START until DONE is asserted.
REQ-010 DONE  output  1  one-cycle pulse; RESULT is valid in this cycle and afterwards.

Function
REQ-011 States SHALL be IDLE, CALC, FIX and FIN; only IDLE accepts a request.
REQ-012 In IDLE, START=1 with a valid SELECT SHALL latch the operands, the operation and the sign flags, and move to CALC.
REQ-013 In IDLE, START=1 with any other SELECT code SHALL be ignored: no state change, BUSY stays 0 and no DONE is produced.
REQ-014 START SHALL be ignored outside IDLE; a request is never queued.
REQ-015 For DIV and REM, the operands SHALL be converted to magnitudes on acceptance; for DIVU and REMU they are used unsigned.
REQ-016 CALC SHALL run restoring division, one quotient bit per cycle, for exactly 32 cycles, counted by a 5-bit counter that wraps from 31 to 0 to exit.
REQ-017 FIX SHALL apply the signs: the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
REQ-018 FIN SHALL register RESULT, assert DONE for one cycle, deassert BUSY and return to IDLE.
REQ-019 Normal latency: with START accepted at edge N, DONE SHALL be high in the cycle after edge N+34.
REQ-020 A new START SHALL be accepted in the cycle immediately after DONE, giving back-to-back throughput of one operation per 35 cycles.
REQ-021 Divide by zero SHALL return a quotient of 0xFFFFFFFF (DIV and DIVU) and a remainder equal to DATA1 (REM and REMU).
REQ-022 Signed overflow (0x80000000 divided by 0xFFFFFFFF) SHALL return a quotient of 0x80000000 for DIV and a remainder of 0 for REM.
REQ-023 Operand inputs SHALL NOT affect an operation in progress after acceptance.

Reset
REQ-024 Asserting RESET SHALL immediately force state=IDLE, RESULT=0, BUSY=0, DONE=0, the counter to 0 and the internal registers to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no DONE; the first START after reset deasserts is accepted normally.

Configuration
REQ-026 The macro DIV_EARLY_OUT_EN SHALL control early completion of the special cases.
REQ-027 When DIV_EARLY_OUT_EN is defined: divide by zero and signed overflow SHALL go from IDLE directly to FIN with the REQ-021/REQ-022 result, and DONE is high in the cycle after edge N+1.
REQ-028 When DIV_EARLY_OUT_EN is not defined: the special cases SHALL take the full REQ-019 latency, with identical results.

Verification
REQ-029 Bench SHALL check DIV: DATA1=100, DATA2=7 -> RESULT=14, DONE 34 cycles after the START edge, BUSY high throughout.
REQ-030 Bench SHALL check REM: DATA1=0xFFFFFFF9 (-7), DATA2=2 -> RESULT=0xFFFFFFFF (-1); and REMU with the same operands -> RESULT=1.
REQ-031 Bench SHALL check divide by zero: DIVU 0x12345678 / 0 -> 0xFFFFFFFF; REM 0x12345678 / 0 -> 0x12345678; latency is 1 cycle with DIV_EARLY_OUT_EN and 34 without.
REQ-032 Bench SHALL check overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-033 Bench SHALL check protocol robustness: a second START at cycle 10 of a DIV is ignored and the operands change at the same time, yet the first RESULT is unchanged; START with SELECT=00000 gives no BUSY.
REQ-034 Bench SHALL check reset mid-operation: RESET pulsed at cycle 20 of a DIV -> BUSY=0, RESULT=0 and no DONE; the next DIV 9/3 -> RESULT=3.
